// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, FSM state type and write-priority helper for regfile_mp_sb
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int MAX_XLEN = 64;
  typedef enum logic {CLEAR, RUN} rf_state_e;
  typedef struct packed {
    logic hit;
    logic [MAX_XLEN-1:0] data;
  } wr_match_t;
  // Folding ports in ascending order leaves the highest-indexed match in acc.
  function automatic wr_match_t wrPick(input wr_match_t acc, input logic match, input logic [MAX_XLEN-1:0] data);
    return match ? '{hit: 1'b1, data: data} : acc;
  endfunction
endpackage

// File: rtl/regfile_bypass_mux.sv
// regfile_bypass_mux: per-read-port priority match of the write ports against one read address
//   rdAddr         read address being looked up
//   wrEn/wrAddr/wrData  packed write ports, higher index has priority
//   hit            some enabled write port targets rdAddr
//   data           write data of the highest-indexed matching port (valid when hit)
module regfile_bypass_mux import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int AW = 5,
  parameter int NWR = 2
) (
  input  logic [AW-1:0]       rdAddr,
  input  logic [NWR-1:0]      wrEn,
  input  logic [NWR*AW-1:0]   wrAddr,
  input  logic [NWR*XLEN-1:0] wrData,
  output logic                hit,
  output logic [XLEN-1:0]     data
);
  wr_match_t m;
  always_comb begin
    m = '0;
    for (int i = 0; i < NWR; i++)
      m = wrPick(m, wrEn[i] && wrAddr[i*AW +: AW] == rdAddr, MAX_XLEN'(wrData[i*XLEN +: XLEN]));
    hit = m.hit;
    data = XLEN'(m.data);
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with registered reads, write-to-read bypass and busy scoreboard
//   clk, resetn         clock, synchronous active-low reset
//   ready               clear engine finished, file usable
//   rd_addr/rd_data/rd_busy  NRD read ports, 1-cycle latency, data and busy reflect this edge's updates
//   wr_en/wr_addr/wr_data    NWR write ports, higher index wins, writes to x0 dropped
//   iss_valid/iss_rd    mark iss_rd busy (set wins over a same-cycle write clear)
//   rd_perr             only with REGFILE_PARITY_EN: stored even parity mismatch on a non-bypassed read
module regfile_mp_sb import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2,
  parameter int NWR = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                resetn,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd
`ifdef REGFILE_PARITY_EN
  ,
  output logic [NRD-1:0]      rd_perr
`endif
);
  rf_state_e state;
  logic [AW-1:0] clrCnt;
  logic [XLEN-1:0] regs [NREGS];
`ifdef REGFILE_PARITY_EN
  logic regPar [NREGS];
`endif
  logic [NREGS-1:0] busy, busyNext;
  logic [AW-1:0] rdA [NRD];
  logic [AW-1:0] wrA [NWR];
  logic [NRD-1:0] bypHit;
  logic [XLEN-1:0] bypData [NRD];
  for (genvar w = 0; w < NWR; w++) begin : g_wr
    assign wrA[w] = wr_addr[w*AW +: AW];
  end
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign rdA[p] = rd_addr[p*AW +: AW];
    regfile_bypass_mux #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_mux (
      .rdAddr(rdA[p]),
      .wrEn(wr_en),
      .wrAddr(wr_addr),
      .wrData(wr_data),
      .hit(bypHit[p]),
      .data(bypData[p])
    );
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= CLEAR;
      clrCnt <= '0;
      ready <= 1'b0;
    end else if (state == CLEAR) begin
      clrCnt <= clrCnt + 1'b1;
      if (clrCnt == AW'(NREGS - 1)) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (state == CLEAR) begin
        regs[clrCnt] <= '0;
`ifdef REGFILE_PARITY_EN
        regPar[clrCnt] <= 1'b0;
`endif
      end else begin
        for (int i = 0; i < NWR; i++)
          if (wr_en[i] && wrA[i] != '0) begin
            regs[wrA[i]] <= wr_data[i*XLEN +: XLEN];
`ifdef REGFILE_PARITY_EN
            regPar[wrA[i]] <= ^wr_data[i*XLEN +: XLEN];
`endif
          end
      end
    end
  end
  // Issue is applied after the write clears so a new producer supersedes the old one.
  always_comb begin
    busyNext = busy;
    for (int i = 0; i < NWR; i++)
      if (wr_en[i]) busyNext[wrA[i]] = 1'b0;
    if (iss_valid && iss_rd != '0) busyNext[iss_rd] = 1'b1;
    busyNext[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!resetn) busy <= '0;
    else if (state == RUN) busy <= busyNext;
  end
  always_ff @(posedge clk) begin
    if (!resetn || state == CLEAR) begin
      rd_data <= '0;
      rd_busy <= '0;
`ifdef REGFILE_PARITY_EN
      rd_perr <= '0;
`endif
    end else begin
      for (int i = 0; i < NRD; i++) begin
        rd_data[i*XLEN +: XLEN] <= rdA[i] == '0 ? '0 : bypHit[i] ? bypData[i] : regs[rdA[i]];
        rd_busy[i] <= busyNext[rdA[i]];
`ifdef REGFILE_PARITY_EN
        rd_perr[i] <= rdA[i] != '0 && !bypHit[i] && (^regs[rdA[i]] != regPar[rdA[i]]);
`endif
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: vector table, random traffic against an array model, and reset/clear sequences
module tb_regfile_mp_sb;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ready;
  logic [9:0] rd_addr;
  logic [63:0] rd_data;
  logic [1:0] rd_busy;
  logic [1:0] wr_en;
  logic [9:0] wr_addr;
  logic [63:0] wr_data;
  logic iss_valid;
  logic [4:0] iss_rd;
`ifdef REGFILE_PARITY_EN
  logic [1:0] rd_perr;
`endif
  regfile_mp_sb dut (
    .clk(clk),
    .resetn(resetn),
    .ready(ready),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_busy(rd_busy),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .iss_valid(iss_valid),
    .iss_rd(iss_rd)
`ifdef REGFILE_PARITY_EN
    ,
    .rd_perr(rd_perr)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] we;
    logic [4:0] wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0] ra0, ra1;
    logic iv;
    logic [4:0] ird;
    logic [31:0] e0, e1;
    logic [1:0] eb;
  } vec_t;
  vec_t tbl [12];
  logic [31:0] mReg [32];
  bit mBusy [32];
  int nVec = 0;
  int nBad = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic [4:0] ra0, input logic [4:0] ra1, input logic iv, input logic [4:0] ird);
    wr_en = we;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    rd_addr = {ra1, ra0};
    iss_valid = iv;
    iss_rd = ird;
  endtask
  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      mReg[i] = '0;
      mBusy[i] = 1'b0;
    end
  endtask
  // Register file state after the current inputs commit; reads see that state.
  task automatic modelStep(output logic [31:0] e0, output logic [31:0] e1, output logic [1:0] eb);
    for (int w = 0; w < 2; w++)
      if (wr_en[w]) begin
        if (wr_addr[w*5 +: 5] != 5'd0) mReg[wr_addr[w*5 +: 5]] = wr_data[w*32 +: 32];
        mBusy[wr_addr[w*5 +: 5]] = 1'b0;
      end
    if (iss_valid && iss_rd != 5'd0) mBusy[iss_rd] = 1'b1;
    e0 = mReg[rd_addr[4:0]];
    e1 = mReg[rd_addr[9:5]];
    eb = {mBusy[rd_addr[9:5]], mBusy[rd_addr[4:0]]};
  endtask
  task automatic clearWindow(input string tag);
    for (int k = 1; k <= 32; k++) begin
      tick();
      check({tag, " ready"}, 64'(ready), 64'(k == 32));
      check({tag, " rd_data"}, rd_data, 64'd0);
    end
  endtask
  initial begin
    logic [31:0] e0, e1;
    logic [1:0] eb;
    tbl[0]  = '{2'b01, 5'd3,  5'd0,  32'hDEADBEEF, 32'h0,    5'd5,  5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        2'b00};
    tbl[1]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd3,  5'd5,  1'b0, 5'd0,  32'hDEADBEEF, 32'h0,        2'b00};
    tbl[2]  = '{2'b01, 5'd7,  5'd0,  32'h11,       32'h0,    5'd7,  5'd3,  1'b0, 5'd0,  32'h11,       32'hDEADBEEF, 2'b00};
    tbl[3]  = '{2'b11, 5'd9,  5'd9,  32'hAAAA,     32'h5555, 5'd9,  5'd9,  1'b0, 5'd0,  32'h5555,     32'h5555,     2'b00};
    tbl[4]  = '{2'b01, 5'd0,  5'd0,  32'hFFFF,     32'h0,    5'd0,  5'd9,  1'b0, 5'd0,  32'h0,        32'h5555,     2'b00};
    tbl[5]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd0,  5'd9,  1'b0, 5'd0,  32'h0,        32'h5555,     2'b00};
    tbl[6]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd12, 5'd0,  1'b1, 5'd12, 32'h0,        32'h0,        2'b01};
    tbl[7]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd12, 5'd12, 1'b0, 5'd0,  32'h0,        32'h0,        2'b11};
    tbl[8]  = '{2'b10, 5'd0,  5'd12, 32'h0,        32'h1234, 5'd12, 5'd7,  1'b0, 5'd0,  32'h1234,     32'h11,       2'b00};
    tbl[9]  = '{2'b01, 5'd12, 5'd0,  32'h77,       32'h0,    5'd12, 5'd12, 1'b1, 5'd12, 32'h77,       32'h77,       2'b11};
    tbl[10] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd0,  5'd12, 1'b1, 5'd0,  32'h0,        32'h77,       2'b10};
    tbl[11] = '{2'b10, 5'd0,  5'd14, 32'h0,        32'hABC,  5'd13, 5'd14, 1'b1, 5'd13, 32'h0,        32'hABC,      2'b01};
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0);
    resetn = 1'b0;
    tick();
    tick();
    check("reset ready", 64'(ready), 64'd0);
    check("reset rd_data", rd_data, 64'd0);
    check("reset rd_busy", 64'(rd_busy), 64'd0);
    resetn = 1'b1;
    clearWindow("clear");
    tick();
    check("post-clear x5", rd_data, 64'd0);
    modelReset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].we, tbl[i].wa0, tbl[i].wa1, tbl[i].wd0, tbl[i].wd1, tbl[i].ra0, tbl[i].ra1, tbl[i].iv, tbl[i].ird);
      modelStep(e0, e1, eb);
      tick();
      check($sformatf("vec%0d rd_data0", i), 64'(rd_data[31:0]), 64'(tbl[i].e0));
      check($sformatf("vec%0d rd_data1", i), 64'(rd_data[63:32]), 64'(tbl[i].e1));
      check($sformatf("vec%0d rd_busy", i), 64'(rd_busy), 64'(tbl[i].eb));
    end
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), $urandom, $urandom,
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)));
      modelStep(e0, e1, eb);
      tick();
      check("rand rd_data0", 64'(rd_data[31:0]), 64'(e0));
      check("rand rd_data1", 64'(rd_data[63:32]), 64'(e1));
      check("rand rd_busy", 64'(rd_busy), 64'(eb));
    end
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd6, 5'd0, 1'b0, 5'd0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    repeat (10) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    drive(2'b01, 5'd6, 5'd0, 32'hBAD, 32'h0, 5'd6, 5'd0, 1'b1, 5'd6);
    clearWindow("restart");
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd6, 5'd0, 1'b0, 5'd0);
    tick();
    check("clear-write x6 data", 64'(rd_data[31:0]), 64'd0);
    check("clear-issue x6 busy", 64'(rd_busy), 64'd0);
    modelReset();
    for (int i = 0; i < 60; i++) begin
      drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      modelStep(e0, e1, eb);
      tick();
      check("rand2 rd_data0", 64'(rd_data[31:0]), 64'(e0));
      check("rand2 rd_data1", 64'(rd_data[63:32]), 64'(e1));
      check("rand2 rd_busy", 64'(rd_busy), 64'(eb));
    end
`ifdef REGFILE_PARITY_EN
    drive(2'b01, 5'd4, 5'd0, 32'h1, 32'h0, 5'd4, 5'd0, 1'b0, 5'd0);
    tick();
    check("bypass perr", 64'(rd_perr), 64'd0);
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd0, 1'b0, 5'd0);
    tick();
    check("clean perr", 64'(rd_perr), 64'd0);
    dut.regs[4] = dut.regs[4] ^ 32'h2;
    tick();
    check("flipped perr", 64'(rd_perr[0]), 64'd1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the ID stage. Replaces the fixed 2R/1W file.
- Provides N read ports and M write ports, with registered reads and same-cycle write-to-read bypass.
- Includes a per-register busy scoreboard for hazard detection and a sequential clear engine run after reset.

Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers; must be a power of 2, ≥2
- NRD, 2, number of read ports
- NWR, 2, number of write ports; higher port index has priority
- AW (localparam), $clog2(NREGS), address width

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- ready  out  1  high when the clear engine is done and the file is usable
- rd_addr  in  NRD*AW  read addresses; port p is at [p*AW +: AW]
- rd_data  out  NRD*XLEN  registered read data
- rd_busy  out  NRD  registered scoreboard bit for each rd_addr
- wr_en  in  NWR  write enables
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- iss_valid  in  1  instruction issued that will write iss_rd
- iss_rd  in  AW  destination register to mark busy

Behaviour:
- Reset: while resetn=0 at posedge clk:
  - state <= CLEAR, clr_cnt <= 0, ready <= 0
  - all busy bits <= 0
  - rd_data <= 0, rd_busy <= 0
  - Array contents are not touched by reset itself.
- FSM, two states:
  - CLEAR: writes regs[clr_cnt] <= 0 each cycle and increments clr_cnt. On clr_cnt == NREGS-1, goes to RUN and sets ready=1. CLEAR takes exactly NREGS cycles after resetn rises.
  - RUN: normal operation. Stays in RUN until reset.
- During CLEAR:
  - wr_en and iss_valid are ignored.
  - rd_data and rd_busy hold 0.
- Reset asserted mid-CLEAR or mid-RUN: returns to CLEAR with clr_cnt=0 on the next edge.
- Register 0:
  - Writes to address 0 are dropped.
  - Reads of address 0 always return 0 with busy=0.
  - iss_rd=0 never sets busy.
- Writes (RUN): on posedge, for each port w with wr_en[w] and wr_addr != 0, regs[wr_addr] <= wr_data.
- Same-address write conflict: the highest-indexed enabled port wins.
- Reads: 1-cycle latency. At posedge, rd_data[p] <= the value regs[rd_addr[p]] will hold after this edge's writes.
  - In other words: if any enabled write port targets rd_addr[p] (nonzero), the winning wr_data is bypassed; otherwise the stored value is returned.
- Scoreboard (RUN):
  - busy[iss_rd] <= 1 when iss_valid.
  - busy[wr_addr[w]] <= 0 for each enabled write.
  - Same register issued and written in the same cycle: set wins, because the new producer supersedes the old one.
- rd_busy[p] is registered with the same bypass rule:
  - Reflects the busy state after this edge's updates.
  - A write clearing the register gives 0; an issue to the register gives 1.
- Different registers updated by different ports in the same cycle are all committed.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Defined:
  - Each register stores an extra even-parity bit computed from the write data; CLEAR writes parity 0.
  - A registered output rd_perr (NRD bits) is added. rd_perr[p] is 1 when the stored parity mismatches the data read on port p.
  - Bypassed reads report 0. Reset value is 0.
- Undefined: no parity storage and no rd_perr port.

Decomposition:
- Package regfile_pkg holds:
  - default XLEN/NREGS constants
  - typedef enum {CLEAR, RUN} rf_state_e
  - function for the highest-priority write match, returning hit plus data
- One sub-module, regfile_bypass_mux: a combinational per-read-port priority bypass. It is instantiated NRD times.

Test Plan:
- Release resetn and hold rd_addr=5: ready is 0 for exactly 32 cycles, then 1. rd_data is 0 throughout and after.
- RUN, write port0 x3=0xDEADBEEF: one cycle later rd_addr=3 returns 0xDEADBEEF. In the same-cycle case (write x7=0x11 with rd_addr=7), rd_data=0x11 on the next edge (bypass).
- Port0 writes x9=0xAAAA and port1 writes x9=0x5555 in the same cycle → x9 reads 0x5555. A write to x0=0xFFFF → x0 reads 0.
- iss_valid with iss_rd=12 → rd_busy=1 for x12. Then wr x12 → busy clears. Issue x12 and write x12 in the same cycle → busy stays 1.
- Assert resetn=0 for one cycle mid-CLEAR at clr_cnt=10 → the counter restarts and ready rises 32 cycles after release. A wr_en during CLEAR leaves the target at 0.
- With REGFILE_PARITY_EN defined, force a stored bit flip on x4 → rd_perr=1 on the next read of x4. A normal write/read gives rd_perr=0.
